// File: rtl/ps_setpoint_mux.sv
`default_nettype none
// ============================================================================
// Module   : ps_setpoint_mux
// Brief    : Merges AWG and FOFB setpoint streams onto the PS link, switching
//            ownership only at packet boundaries. Optional FOFB drop counter
//            is built when PS_SETPOINT_MUX_DROP_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ps_setpoint_mux #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    COUNTER_WIDTH = 16,
  parameter string DEBUG         = "false"
) (
  input  logic                     sysClk,
  input  logic                     sysReset_n,
  input  logic                     AWGrequest,
  output logic                     AWGenabled,
  input  logic [DATA_WIDTH-1:0]    awgTDATA,
  input  logic                     awgTVALID,
  input  logic                     awgTLAST,
  input  logic [DATA_WIDTH-1:0]    fofbTDATA,
  input  logic                     fofbTVALID,
  input  logic                     fofbTLAST,
  output logic [DATA_WIDTH-1:0]    psTDATA,
  output logic                     psTVALID,
  output logic                     psTLAST,
  output logic                     psTUSER,
  input  logic                     countersClear,
  output logic [31:0]              status,
  output logic [COUNTER_WIDTH-1:0] awgPacketCount
);

  typedef enum logic [1:0] {
    ST_FOFB    = 2'd0,
    ST_TO_AWG  = 2'd1,
    ST_AWG     = 2'd2,
    ST_TO_FOFB = 2'd3
  } state_t;

  state_t                  r_state, w_nextState;
  logic                    r_awgEnabled, w_awgEnabledNext;
  logic                    r_awgAligned, r_fofbAligned;
  logic                    r_awgInPkt, r_fofbInPkt, r_fofbDrop;
  logic                    r_psTVALID, r_psTLAST, r_psTUSER;
  logic [DATA_WIDTH-1:0]   r_psTDATA;
  logic [COUNTER_WIDTH-1:0] r_awgPacketCount;
  logic                    w_awgBeat, w_fofbBeat, w_awgSide;
  logic                    w_fofbDropBeat, w_fwdAwg, w_fwdFofb;
  logic [15:0]             w_drop16;
  logic [1:0]              w_stateTap;
  logic [DATA_WIDTH+2:0]   w_stream, w_streamTap;

  // Unaligned sources are invisible to everything except their alignment flag.
  assign w_awgBeat      = awgTVALID & r_awgAligned;
  assign w_fofbBeat     = fofbTVALID & r_fofbAligned;
  assign w_awgSide      = (r_state == ST_AWG) || (r_state == ST_TO_FOFB);
  assign w_fofbDropBeat = w_fofbBeat & (r_fofbInPkt ? r_fofbDrop : w_awgSide);
  assign w_fwdFofb      = w_fofbBeat & ~w_fofbDropBeat & ~w_awgSide;
  assign w_fwdAwg       = w_awgBeat & w_awgSide;

  always_comb begin
    w_nextState      = r_state;
    w_awgEnabledNext = r_awgEnabled;
    case (r_state)
      ST_FOFB: begin
        if (AWGrequest) w_nextState = ST_TO_AWG;
      end
      ST_TO_AWG: begin
        if (!AWGrequest) begin
          w_nextState = ST_FOFB;
        end else if ((!r_fofbInPkt && !w_fofbBeat) || (w_fofbBeat && fofbTLAST)) begin
          w_nextState      = ST_AWG;
          w_awgEnabledNext = 1'b1;
        end
      end
      ST_AWG: begin
        if (!AWGrequest) w_nextState = ST_TO_FOFB;
      end
      ST_TO_FOFB: begin
        if (AWGrequest) begin
          w_nextState = ST_AWG;
        end else if ((!r_awgInPkt && !w_awgBeat) || (w_awgBeat && awgTLAST)) begin
          w_nextState      = ST_FOFB;
          w_awgEnabledNext = 1'b0;
        end
      end
      default: w_nextState = ST_FOFB;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_state       <= ST_FOFB;
      r_awgEnabled  <= 1'b0;
      r_awgAligned  <= 1'b0;
      r_fofbAligned <= 1'b0;
      r_awgInPkt    <= 1'b0;
      r_fofbInPkt   <= 1'b0;
      r_fofbDrop    <= 1'b0;
      r_psTVALID    <= 1'b0;
      r_psTLAST     <= 1'b0;
      r_psTUSER     <= 1'b0;
      r_psTDATA     <= '0;
    end else begin
      r_state      <= w_nextState;
      r_awgEnabled <= w_awgEnabledNext;
      if (awgTVALID && awgTLAST)   r_awgAligned  <= 1'b1;
      if (fofbTVALID && fofbTLAST) r_fofbAligned <= 1'b1;
      if (w_awgBeat) r_awgInPkt <= ~awgTLAST;
      if (w_fofbBeat) begin
        r_fofbInPkt <= ~fofbTLAST;
        r_fofbDrop  <= ~fofbTLAST & w_fofbDropBeat;
      end
      r_psTVALID <= w_fwdAwg | w_fwdFofb;
      r_psTLAST  <= (w_fwdAwg & awgTLAST) | (w_fwdFofb & fofbTLAST);
      r_psTUSER  <= w_fwdAwg;
      if (w_fwdAwg)       r_psTDATA <= awgTDATA;
      else if (w_fwdFofb) r_psTDATA <= fofbTDATA;
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n)                                       r_awgPacketCount <= '0;
    else if (countersClear)                                r_awgPacketCount <= '0;
    else if (w_fwdAwg && awgTLAST && !(&r_awgPacketCount)) r_awgPacketCount <= r_awgPacketCount + 1'b1;
  end

`ifdef PS_SETPOINT_MUX_DROP_COUNT_EN
  logic [COUNTER_WIDTH-1:0] r_dropCount;

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n)                                         r_dropCount <= '0;
    else if (countersClear)                                  r_dropCount <= '0;
    else if (w_fofbDropBeat && fofbTLAST && !(&r_dropCount)) r_dropCount <= r_dropCount + 1'b1;
  end

  if (COUNTER_WIDTH >= 16) begin : g_dropTrunc
    assign w_drop16 = r_dropCount[15:0];
  end else begin : g_dropExt
    assign w_drop16 = {{(16-COUNTER_WIDTH){1'b0}}, r_dropCount};
  end
`else
  assign w_drop16 = 16'h0000;
`endif

  assign w_stream = {r_psTUSER, r_psTLAST, r_psTVALID, r_psTDATA};

  if (DEBUG == "true") begin : g_debugMark
    (* mark_debug = "true" *) logic [1:0]            w_dbgState;
    (* mark_debug = "true" *) logic [DATA_WIDTH+2:0] w_dbgStream;
    assign w_dbgState  = r_state;
    assign w_dbgStream = w_stream;
    assign w_stateTap  = w_dbgState;
    assign w_streamTap = w_dbgStream;
  end else begin : g_debugPlain
    assign w_stateTap  = r_state;
    assign w_streamTap = w_stream;
  end

  assign {psTUSER, psTLAST, psTVALID, psTDATA} = w_streamTap;
  assign AWGenabled     = r_awgEnabled;
  assign awgPacketCount = r_awgPacketCount;
  assign status         = {AWGrequest, r_awgEnabled, w_stateTap, 12'h000, w_drop16};

endmodule
`default_nettype wire

// File: tb/tb_ps_setpoint_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_setpoint_mux
// Brief    : Directed and random stimulus for ps_setpoint_mux, compared each
//            cycle against an ownership/packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_setpoint_mux;

  localparam int         DW   = 32;
  localparam int         CW   = 16;
  localparam logic [15:0] CMAX = 16'hFFFF;

  logic          sysClk = 1'b0;
  logic          sysReset_n;
  logic          AWGrequest;
  logic          AWGenabled;
  logic [DW-1:0] awgTDATA, fofbTDATA, psTDATA;
  logic          awgTVALID, awgTLAST, fofbTVALID, fofbTLAST;
  logic          psTVALID, psTLAST, psTUSER;
  logic          countersClear;
  logic [31:0]   status;
  logic [CW-1:0] awgPacketCount;

  ps_setpoint_mux #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .DEBUG("false")) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n),
    .AWGrequest(AWGrequest), .AWGenabled(AWGenabled),
    .awgTDATA(awgTDATA), .awgTVALID(awgTVALID), .awgTLAST(awgTLAST),
    .fofbTDATA(fofbTDATA), .fofbTVALID(fofbTVALID), .fofbTLAST(fofbTLAST),
    .psTDATA(psTDATA), .psTVALID(psTVALID), .psTLAST(psTLAST), .psTUSER(psTUSER),
    .countersClear(countersClear), .status(status), .awgPacketCount(awgPacketCount)
  );

  always #5 sysClk = ~sysClk;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model: who owns the link, whether a handover is pending,
  // and per-source packet bookkeeping.
  bit          mGranted, mPending;
  bit          mAwgAligned, mFofbAligned, mAwgInPkt, mFofbInPkt, mFofbPktDropped;
  bit          expValid, expLast, expUser;
  logic [31:0] expData;
  logic [15:0] mAwgCount, mDropCount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mGranted = 0; mPending = 0;
    mAwgAligned = 0; mFofbAligned = 0; mAwgInPkt = 0; mFofbInPkt = 0; mFofbPktDropped = 0;
    expValid = 0; expLast = 0; expUser = 0; expData = '0;
    mAwgCount = '0; mDropCount = '0;
  endtask

  task automatic modelStep();
    bit aBeat, fBeat, fDropPkt, fwdA, fwdF, wantSwitch, safe;
    aBeat    = awgTVALID && mAwgAligned;
    fBeat    = fofbTVALID && mFofbAligned;
    fDropPkt = mFofbInPkt ? mFofbPktDropped : mGranted;
    fwdA     = aBeat && mGranted;
    fwdF     = fBeat && !fDropPkt && !mGranted;
    expValid = fwdA || fwdF;
    expUser  = fwdA;
    expLast  = fwdA ? awgTLAST : (fwdF ? fofbTLAST : 1'b0);
    if (fwdA) expData = awgTDATA;
    else if (fwdF) expData = fofbTDATA;
    if (countersClear) begin
      mAwgCount = '0; mDropCount = '0;
    end else begin
      if (fwdA && awgTLAST && mAwgCount != CMAX) mAwgCount++;
      if (fBeat && fofbTLAST && fDropPkt && mDropCount != CMAX) mDropCount++;
    end
    // A handover completes once the current owner will not be mid-packet after this cycle.
    wantSwitch = (AWGrequest != mGranted);
    safe = mGranted ? (aBeat ? awgTLAST : !mAwgInPkt) : (fBeat ? fofbTLAST : !mFofbInPkt);
    if (mPending && wantSwitch && safe) begin
      mGranted = !mGranted; mPending = 0;
    end else begin
      mPending = wantSwitch;
    end
    if (aBeat) mAwgInPkt = !awgTLAST;
    if (fBeat) begin
      if (!mFofbInPkt) mFofbPktDropped = fDropPkt;
      mFofbInPkt = !fofbTLAST;
    end
    if (awgTVALID && awgTLAST)   mAwgAligned  = 1;
    if (fofbTVALID && fofbTLAST) mFofbAligned = 1;
  endtask

  function automatic logic [15:0] expDrop16();
`ifdef PS_SETPOINT_MUX_DROP_COUNT_EN
    return mDropCount;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic compareAll();
    check("psTVALID", 32'(psTVALID), 32'(expValid));
    if (expValid) begin
      check("psTDATA", psTDATA, expData);
      check("psTLAST", 32'(psTLAST), 32'(expLast));
      check("psTUSER", 32'(psTUSER), 32'(expUser));
    end
    check("AWGenabled", 32'(AWGenabled), 32'(mGranted));
    check("status", status, {AWGrequest, mGranted, mGranted, mPending, 12'h000, expDrop16()});
    check("awgPacketCount", 32'(awgPacketCount), 32'(mAwgCount));
  endtask

  task automatic tick();
    @(posedge sysClk);
    if (sysReset_n) modelStep();
    #1;
    compareAll();
  endtask

  task automatic drive(input bit aV, input bit aL, input logic [31:0] aD,
                       input bit fV, input bit fL, input logic [31:0] fD);
    awgTVALID = aV; awgTLAST = aL; awgTDATA = aD;
    fofbTVALID = fV; fofbTLAST = fL; fofbTDATA = fD;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    int aRem, fRem, waitCnt;
    bit aV, aL, fV, fL;
    sysReset_n = 0; AWGrequest = 0; countersClear = 0;
    awgTVALID = 0; awgTLAST = 0; awgTDATA = '0;
    fofbTVALID = 0; fofbTLAST = 0; fofbTDATA = '0;
    modelReset();

    // Reset state, then release in the middle of a FOFB packet.
    idle();
    check("reset_status", status, 32'h0);
    drive(0, 0, 0, 1, 0, 32'hA0);
    sysReset_n = 1;
    drive(0, 0, 0, 1, 0, 32'hA1);
    drive(0, 0, 0, 1, 0, 32'hA2);
    drive(0, 0, 0, 1, 1, 32'hA3);
    check("tail_dropped", 32'(psTVALID), 32'h0);
    drive(1, 1, 32'hEE, 1, 0, 32'h10);
    drive(0, 0, 0, 1, 0, 32'h11);
    drive(0, 0, 0, 1, 0, 32'h12);
    drive(0, 0, 0, 1, 1, 32'h13);
    check("first_pkt_end", {psTVALID, psTLAST, psTUSER, psTDATA[28:0]}, {3'b110, 29'h13});

    // Request arrives mid FOFB packet: packet completes, then grant.
    drive(0, 0, 0, 1, 0, 32'h20);
    AWGrequest = 1;
    for (int i = 1; i < 5; i++) drive(0, 0, 0, 1, 0, 32'h20 + i);
    check("no_grant_midpkt", 32'(AWGenabled), 32'h0);
    drive(0, 0, 0, 1, 1, 32'h25);
    check("grant_after_last", 32'(AWGenabled), 32'h1);
    check("grant_state", 32'(status[29:28]), 32'h2);

    // Owned by AWG: interleaved FOFB packets are dropped and counted.
    countersClear = 1; idle(); countersClear = 0;
    for (int i = 0; i < 16; i++)
      drive(1, (i % 8) == 7, 32'h100 + i, (i < 14) && (i % 5) < 4, (i % 5) == 3, 32'h200 + i);
    idle();
    check("awg_pkts", 32'(awgPacketCount), 32'h2);
`ifdef PS_SETPOINT_MUX_DROP_COUNT_EN
    check("drop_count3", 32'(status[15:0]), 32'h3);
`else
    check("drop_count3", 32'(status[15:0]), 32'h0);
`endif

    // Release mid AWG packet; FOFB packet begun meanwhile is dropped whole.
    for (int i = 0; i < 10; i++) begin
      if (i == 2) AWGrequest = 0;
      drive(i < 8, i == 7, 32'h500 + i, i >= 4, i == 9, 32'h600 + i);
      if (i == 7) check("release_after_last", 32'(AWGenabled), 32'h0);
      if (i == 9) check("late_drop", 32'(psTVALID), 32'h0);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, i == 2, 32'h300 + i);
    check("fofb_resumes", {psTVALID, psTLAST, psTUSER, psTDATA[28:0]}, {3'b110, 29'h302});

    // Clear coincident with a dropped FOFB TLAST.
    AWGrequest = 1;
    waitCnt = 0;
    while (!AWGenabled && waitCnt < 10) begin idle(); waitCnt++; end
    check("grant_timeout", 32'(AWGenabled), 32'h1);
    drive(0, 0, 0, 1, 0, 32'h400);
    countersClear = 1;
    drive(0, 0, 0, 1, 1, 32'h401);
    countersClear = 0;
    check("clear_priority", 32'(status[15:0]), 32'h0);

    // Saturation of the drop counter.
    for (int i = 0; i < 70000; i++) drive(0, 0, 0, 1, 1, i);
    idle();
`ifdef PS_SETPOINT_MUX_DROP_COUNT_EN
    check("drop_saturate", 32'(status[15:0]), 32'hFFFF);
`else
    check("drop_saturate", 32'(status[15:0]), 32'h0);
`endif

    // Randomized traffic with request toggles, clears and async resets.
    aRem = 0; fRem = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) AWGrequest = ~AWGrequest;
      countersClear = ($urandom_range(63) == 0);
      if (aRem == 0 && $urandom_range(2) == 0) aRem = $urandom_range(8, 1);
      if (fRem == 0 && $urandom_range(2) == 0) fRem = $urandom_range(8, 1);
      aV = (aRem > 0) && ($urandom_range(3) != 0);
      aL = aV && (aRem == 1);
      if (aV) aRem--;
      fV = (fRem > 0) && ($urandom_range(3) != 0);
      fL = fV && (fRem == 1);
      if (fV) fRem--;
      drive(aV, aL, $urandom, fV, fL, $urandom);
      if ($urandom_range(999) == 0) begin
        sysReset_n = 0;
        #1;
        modelReset();
        compareAll();
        tick();
        sysReset_n = 1;
      end
    end
    countersClear = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps_setpoint_mux.md
Name: ps_setpoint_mux

Overview:
- Sits directly downstream of the power-supply AWG.
- Merges the AWG setpoint stream and the fast-orbit-feedback (FOFB) setpoint stream into the single stream that feeds the power-supply link serializer.
- Grants AWGenabled only at packet boundaries, so no output packet ever mixes sources.
- Counts FOFB packets discarded while the AWG owns the link.

Parameters:
- DATA_WIDTH, 32, width of all TDATA buses.
- COUNTER_WIDTH, 16, width of the drop and AWG packet counters; counters saturate at all-ones.
- DEBUG, "false", mark_debug value applied to the state register and the output stream.

Ports:
- sysClk  in  1  system clock; all logic in this domain.
- sysReset_n  in  1  asynchronous, active-low reset.
- AWGrequest  in  1  level request from the AWG control register.
- AWGenabled  out  1  grant to the AWG; the AWG runs only while this is high.
- awgTDATA  in  DATA_WIDTH  AWG setpoint beat.
- awgTVALID  in  1  AWG beat valid (no TREADY; this block must never stall it).
- awgTLAST  in  1  last beat of an AWG packet.
- fofbTDATA  in  DATA_WIDTH  FOFB setpoint beat.
- fofbTVALID  in  1  FOFB beat valid (no backpressure).
- fofbTLAST  in  1  last beat of an FOFB packet.
- psTDATA  out  DATA_WIDTH  merged setpoint beat.
- psTVALID  out  1  merged beat valid.
- psTLAST  out  1  merged end of packet.
- psTUSER  out  1  1 = beat originated from the AWG.
- countersClear  in  1  single-cycle strobe; zeroes both counters.
- status  out  32  {AWGrequest, AWGenabled, state[1:0], 12'b0, dropCount[15:0]}, with dropCount zero-extended or truncated to 16 bits.
- awgPacketCount  out  COUNTER_WIDTH  AWG packets forwarded.

Behaviour:
- Reset (asynchronous): AWGenabled=0; psTVALID/psTLAST/psTUSER=0; psTDATA=0; state=ST_FOFB; counters=0; inPkt flags=0; aligned flags=0.
- Alignment:
  - Each source has an aligned flag, set by the first beat with TLAST after reset.
  - Beats from an unaligned source are silently discarded and not counted, so a packet tail straddling reset never reaches the output.
- inPkt flags:
  - inPkt tracks each source: set on a valid non-last beat, cleared on a valid TLAST beat.
  - A single-beat packet leaves inPkt at 0.
- Latency: one sysClk from input beat to output; the output is fully registered. psTVALID is 0 in every cycle with no forwarded beat.
- State ST_FOFB (0):
  - FOFB beats are forwarded with psTUSER=0.
  - AWG beats are ignored.
  - If AWGrequest=1 → ST_TO_AWG.
- State ST_TO_AWG (1):
  - FOFB beats continue to be forwarded.
  - When fofbInPkt=0 and no FOFB beat is valid this cycle, or the current FOFB beat has TLAST: AWGenabled<=1 and go to ST_AWG.
  - If AWGrequest drops first → ST_FOFB.
- State ST_AWG (2):
  - AWG beats are forwarded with psTUSER=1.
  - Each forwarded AWG TLAST increments awgPacketCount.
  - A FOFB packet is dropped whole only if it starts in this state; dropCount increments on its TLAST beat (a single-beat packet counts on that beat).
  - Any FOFB packet already in flight when entering this state was completed in ST_TO_AWG.
  - If AWGrequest=0 → ST_TO_FOFB.
- State ST_TO_FOFB (3):
  - AWG beats still forwarded.
  - When awgInPkt=0 and no AWG beat is valid this cycle, or the current AWG beat has TLAST: AWGenabled<=0 and go to ST_FOFB.
  - FOFB packets starting while in ST_AWG or ST_TO_FOFB are dropped to completion, even after return to ST_FOFB.
  - Forwarding of FOFB resumes at the next FOFB packet start.
  - If AWGrequest returns to 1 → ST_AWG.
- Simultaneous events:
  - At most one source is forwarded per cycle.
  - The non-selected source's beat is dropped, never queued.
  - countersClear has priority over an increment in the same cycle.
- Saturation: counters stop at 2^COUNTER_WIDTH-1.
- Reset mid-packet: output drops immediately; the next output packet is always complete.

Optional Feature:
- Macro PS_SETPOINT_MUX_DROP_COUNT_EN.
- Defined: dropCount is implemented as above.
- Undefined: no drop counter is synthesized, status[15:0]=0, and the drop logic still discards packets.

Test Plan:
- Reset release mid-FOFB packet: 3 beats then TLAST, then a 4-beat packet 0x10..0x13 → only 0x10..0x13 appear on the output, psTLAST on 0x13, psTUSER=0.
- AWGrequest=1 at beat 2 of a 6-beat FOFB packet → all 6 beats forwarded; AWGenabled rises the cycle after the FOFB TLAST beat; status[29:28]=2.
- ST_AWG with three 4-beat FOFB packets and two 8-beat AWG packets → output carries only the AWG beats with psTUSER=1; dropCount=3; awgPacketCount=2.
- AWGrequest=0 at AWG beat 3 of 8 → beats 4..8 forwarded; AWGenabled falls the cycle after AWG TLAST; a FOFB packet begun during beat 5 is fully dropped; the next FOFB packet is forwarded.
- countersClear asserted in the same cycle as a dropped FOFB TLAST → dropCount=0 the next cycle.
- 70000 dropped single-beat FOFB packets with COUNTER_WIDTH=16 → dropCount=0xFFFF; with the macro undefined, status[15:0]=0.
